accum_ctrl: RTL and testbench

Tile-level sequencer for the carry-save partial-sum accumulator at the bottom of each systolic column. It accepts a stream of signed 16-bit result pairs from the array and holds the carry-save pair in registers. For each pair it steps one `accumulator_rev` instance. On the last beat of a tile it resolves the carry-save pair with a carry-propagate add and presents the tile sum on a valid/ready output.

---
 rtl/systolic_pkg.sv | 34 +++
 rtl/accumulator_rev.sv | 31 +++
 rtl/accum_ctrl.sv | 158 +++++++++++++++
 tb/tb_accum_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic column accumulator: width helpers,
// controller state encoding and the 16-bit saturation limits.
package systolic_pkg;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

  // Accumulator width: enough headroom for ARRAYSIZE/2 beats of two 16-bit lanes.
  function automatic int acc_w(input int arraysize);
    return clog2(arraysize) + 16;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    OUT     = 2'd3
  } accctrl_state_e;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/accumulator_rev.sv
// Combinational carry-save step: folds two signed 16-bit results into a
// carry-save partial-sum pair using two 3:2 compressor levels.
module accumulator_rev
  import systolic_pkg::*;
#(
  parameter int arraysize = 16
) (
  input  logic [acc_w(arraysize)-1:0] psum0,
  input  logic [acc_w(arraysize)-1:0] psum1,
  input  logic [15:0]                 res0,
  input  logic [15:0]                 res1,
  output logic [acc_w(arraysize)-1:0] sum0,
  output logic [acc_w(arraysize)-1:0] sum1
);
  localparam int ACCW = acc_w(arraysize);

  logic [ACCW-1:0] r0_ext;
  logic [ACCW-1:0] r1_ext;
  logic [ACCW-1:0] x1;
  logic [ACCW-1:0] c1;

  always_comb begin
    r0_ext = {{(ACCW-16){res0[15]}}, res0};
    r1_ext = {{(ACCW-16){res1[15]}}, res1};
    x1     = psum0 ^ psum1 ^ r0_ext;
    c1     = ((psum0 & psum1) | (psum0 & r0_ext) | (psum1 & r0_ext)) << 1;
    sum0   = x1 ^ c1 ^ r1_ext;
    sum1   = ((x1 & c1) | (x1 & r1_ext) | (c1 & r1_ext)) << 1;
  end

endmodule

// File: rtl/accum_ctrl.sv
// Tile sequencer around accumulator_rev: accepts beats, resolves the carry-save
// pair at tile end and presents the sum. Optional clamp: ACCCTRL_SAT_EN.
module accum_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAYSIZE = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [15:0]                 res0,
  input  logic [15:0]                 res1,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [acc_w(ARRAYSIZE)-1:0] out_data,
  output logic                        out_err,
  output logic                        out_sat
);
  localparam int ACCW     = acc_w(ARRAYSIZE);
  localparam int MAXBEATS = ARRAYSIZE / 2;
  localparam int CNTW     = clog2(MAXBEATS + 1);

  // Handshake: a beat moves when in_valid && in_ready; the tile sum moves when
  // out_valid && out_ready. Outputs stay stable while out_valid && !out_ready.
  accctrl_state_e  state_q, state_d;
  logic [ACCW-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [ACCW-1:0] out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic [ACCW-1:0] psum0, psum1, acc0, acc1, sum;
  logic            accept;
  logic            take_beat;

  accumulator_rev #(.arraysize(ARRAYSIZE)) u_acc (
    .psum0(psum0),
    .psum1(psum1),
    .res0 (res0),
    .res1 (res1),
    .sum0 (acc0),
    .sum1 (acc1)
  );

  assign in_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept   = in_valid && in_ready;
  // A first beat starts from zero rather than whatever the last tile left behind.
  assign psum0    = (state_q == IDLE) ? '0 : s0_q;
  assign psum1    = (state_q == IDLE) ? '0 : s1_q;
  assign cnt_inc  = ((state_q == IDLE) ? '0 : cnt_q) + CNTW'(1);
  assign sum      = s0_q + s1_q;

`ifdef ACCCTRL_SAT_EN
  logic            out_sat_q, out_sat_d;
  logic            sat_hi, sat_lo;
  assign sat_hi = $signed(sum) > $signed(ACCW'(SAT_MAX));
  assign sat_lo = $signed(sum) < $signed(ACCW'(SAT_MIN));
  assign out_sat = out_sat_q;
`else
  assign out_sat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
`ifdef ACCCTRL_SAT_EN
    out_sat_d   = out_sat_q;
`endif
    take_beat   = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (state_q == IDLE) cnt_d = '0;
        if (abort) begin
          // Any beat offered alongside abort is consumed and dropped.
          state_d = IDLE;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (accept) begin
          take_beat = 1'b1;
        end
        if (take_beat) begin
          s0_d  = acc0;
          s1_d  = acc1;
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d = RESOLVE;
          end else if (cnt_inc == CNTW'(MAXBEATS)) begin
            state_d = RESOLVE;
            err_d   = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      RESOLVE: begin
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        out_data_d  = sum;
`ifdef ACCCTRL_SAT_EN
        out_sat_d   = sat_hi || sat_lo;
        if (sat_hi) out_data_d = ACCW'(SAT_MAX);
        else if (sat_lo) out_data_d = ACCW'(SAT_MIN);
`endif
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s0_q        <= '0;
      s1_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
`ifdef ACCCTRL_SAT_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
`ifdef ACCCTRL_SAT_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl: integer tile model feeds an expected queue,
// popped and checked whenever the controller presents a tile sum.
module tb_accum_ctrl;
  import systolic_pkg::*;

  localparam int ARRAYSIZE = 16;
  localparam int ACCW      = acc_w(ARRAYSIZE);
  localparam int MAXBEATS  = ARRAYSIZE / 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [15:0]     res0;
  logic [15:0]     res1;
  logic            abort;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            out_err;
  logic            out_sat;

  logic [ACCW-1:0] exp_q[$];
  logic            exp_err_q[$];
  logic            exp_sat_q[$];

  int checks;
  int errors;
  int model_acc;
  int model_beats;

  accum_ctrl #(.ARRAYSIZE(ARRAYSIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .res0     (res0),
    .res1     (res1),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_sat  (out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_expected(input int total, input logic err);
    logic [ACCW-1:0] d;
    logic            s;
    d = ACCW'(total);
    s = 1'b0;
`ifdef ACCCTRL_SAT_EN
    if (total > 32767) begin
      d = ACCW'(32767);
      s = 1'b1;
    end else if (total < -32768) begin
      d = ACCW'(-32768);
      s = 1'b1;
    end
`endif
    exp_q.push_back(d);
    exp_err_q.push_back(err);
    exp_sat_q.push_back(s);
  endtask

  // Offer one beat and hold it until accepted; updates the tile model.
  task automatic beat(input int a, input int b, input logic last, input logic ab);
    in_valid = 1'b1;
    res0     = 16'(a);
    res1     = 16'(b);
    in_last  = last;
    abort    = ab;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    abort    = 1'b0;
    if (ab) begin
      model_acc   = 0;
      model_beats = 0;
    end else begin
      model_acc   = model_acc + a + b;
      model_beats = model_beats + 1;
      if (last || model_beats == MAXBEATS) begin
        push_expected(model_acc, !last);
        model_acc   = 0;
        model_beats = 0;
      end
    end
  endtask

  task automatic wait_out(input int budget, output logic [ACCW-1:0] exp_d);
    exp_d = '0;
    for (int i = 0; i < budget && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_d = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("out_err", 32'(out_err), 32'(exp_err_q.pop_front()));
        chk("out_sat", 32'(out_sat), 32'(exp_sat_q.pop_front()));
      end
    end
  endtask

  task automatic idle_no_out(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [ACCW-1:0] held;
    checks      = 0;
    errors      = 0;
    model_acc   = 0;
    model_beats = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    res0        = '0;
    res1        = '0;
    abort       = 1'b0;
    out_ready   = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal tile, with latency check: RESOLVE cycle first, then output.
    beat(100, -3, 1'b0, 1'b0);
    beat(-50, 7, 1'b1, 1'b0);
    chk("lat_resolve_valid", 32'(out_valid), 32'd0);
    chk("lat_resolve_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    wait_out(0, held);
    chk("normal_value", 32'(held), 32'(ACCW'(54)));

    // Max-length guard: no in_last, forced termination.
    for (int i = 0; i < MAXBEATS; i++) beat(32767, 32767, 1'b0, 1'b0);
    wait_out(4, held);

    // Negative extreme reached exactly.
    for (int i = 0; i < MAXBEATS; i++) beat(-32768, -32768, i == MAXBEATS - 1, 1'b0);
    wait_out(4, held);

    // Backpressure: output held, input stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    beat(3, 4, 1'b1, 1'b0);
    wait_out(4, held);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Abort in ACC wins over in_last.
    for (int i = 0; i < 3; i++) beat(10, 10, 1'b0, 1'b0);
    beat(5, 5, 1'b1, 1'b1);
    idle_no_out(4, "abort_no_out");
    beat(1, 1, 1'b1, 1'b0);
    wait_out(4, held);

    // Abort in IDLE swallows the beat.
    @(posedge clk);
    #1;
    beat(9, 9, 1'b1, 1'b1);
    idle_no_out(3, "idle_abort_no_out");
    beat(-1, -2, 1'b1, 1'b0);
    wait_out(4, held);

    // Asynchronous reset mid-tile.
    @(posedge clk);
    #1;
    beat(7, 8, 1'b0, 1'b0);
    beat(7, 8, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    model_acc   = 0;
    model_beats = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_no_out(3, "post_rst_no_out");
    beat(5, -5, 1'b1, 1'b0);
    wait_out(4, held);

    // Random short tiles.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(1, MAXBEATS));
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++)
        beat(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             i == n - 1, 1'b0);
      wait_out(4, held);
    end

    @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
